prbs5_checker: RTL
==================

Name: prbs5_checker

Overview:
- Receive-side partner of the 5-bit XNOR LFSR stream generator (feedback ~(q[2]^q[4]), new bit shifted into q[0], period 31).
- Consumes one serial bit per valid cycle and self-synchronises to the sequence.
- Declares lock, then counts bit errors against a free-running local reference.
- Sits at the stream sink, in parallel with the serial pattern detectors, and reports link quality.

Parameters:
LOCK_COUNT, 8, consecutive correct predictions in HUNT needed to declare lock
WINDOW, 32, valid bits per error-monitoring window while LOCKED
UNLOCK_ERRS, 4, errors within one window that force loss of lock
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
din_valid  input  1  din is sampled on this edge
din  input  1  serial data bit
clear_cnt  input  1  synchronous clear of err_count
locked  output  1  checker is synchronised
err_pulse  output  1  one-cycle pulse, the bit just sampled mismatched while LOCKED
lock_lost  output  1  one-cycle pulse on the LOCKED->SEED transition
err_count  output  ERR_CNT_W  saturating count of errors seen while LOCKED

Behaviour:
- Reset (async, rst=1): state=SEED; sr=0; all counters=0; locked=0, err_pulse=0, lock_lost=0, err_count=0. Reset mid-operation discards all sync and count state immediately.
- sr[4:0] holds history; newest bit in sr[0]. pred = ~(sr[2]^sr[4]).
- Nothing advances on edges with din_valid=0. Pulses deassert on any edge where they are not re-asserted.
- SEED:
  - Shift din into sr on each valid bit.
  - After the 5th valid bit, go to HUNT with match_cnt=0.
- HUNT:
  - Each valid bit: if din==pred, match_cnt++; else match_cnt=0. Shift din into sr in both cases.
  - Lockup guard: if the shifted-in sr==5'b11111, match_cnt is forced to 0. A stuck-high line never locks.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1 on the same edge.
  - Window counters start at 0.
- LOCKED:
  - Each valid bit: shift pred, not din, into sr, so a single bit error counts once.
  - If din!=pred: err_pulse=1, err_count++ (saturates at all-ones), win_errs++.
  - win_bits++. When win_bits reaches WINDOW, clear win_bits and win_errs.
  - If win_errs reaches UNLOCK_ERRS: go to SEED, locked=0, lock_lost=1. err_pulse is still asserted for the 4th error. err_count is retained.
  - If the last window bit is also the UNLOCK_ERRS-th error, unlock wins.
- clear_cnt=1: err_count=0 on that edge. If an error occurs on the same edge, err_count=1. clear_cnt does not affect lock state or window counters.
- Latency: all outputs are registered and reflect the bit sampled at the previous valid edge.

Decomposition:
- prbs_pkg holds:
  - the state enum (SEED, HUNT, LOCKED)
  - TAP_A=2, TAP_B=4, LFSR_W=5
  - the all-ones lockup constant
  - a function prbs5_next(sr) returning the predicted bit (shared with the generator).
- One sub-module, prbs_err_window: owns win_bits, win_errs and the unlock decision. Inputs: valid, err, locked. Output: unlock.
- The main block owns the FSM, sr, match_cnt and err_count.

Test Plan:
- Generator stream from reset (1,1,1,0,0,1,0,0,0,...), din_valid=1 every cycle -> locked rises at the 13th valid edge (5 seed + 8 matches); err_pulse stays 0 for 200 bits; err_count=0.
- Same stream with bit 40 inverted -> exactly one err_pulse, one cycle after that bit's edge; err_count=1; locked stays 1.
- Invert 4 bits within one 32-bit window -> err_count=4; lock_lost pulses with the 4th err_pulse; locked=0; relock 13 valid bits later.
- din held at 1 for 100 bits -> locked never asserts.
- din_valid toggling 1/0 with the generator gated identically -> lock after 13 valid bits, i.e. 26 clocks.
- clear_cnt asserted on the same edge as an error with err_count=3 -> err_count=1.
- rst asserted mid-LOCKED -> locked=0 and err_count=0 asynchronously; re-lock requires a full SEED+HUNT.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS5 generator/checker pair: state encoding,
// LFSR geometry and the next-bit predictor.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    localparam int LFSR_W = 5;
    localparam int TAP_A  = 2;
    localparam int TAP_B  = 4;

    // The XNOR LFSR can never leave the all-ones state, so it must never count as sync.
    localparam logic [LFSR_W-1:0] LOCKUP = '1;

    function automatic logic prbs5_next(input logic [LFSR_W-1:0] sr);
        return ~(sr[TAP_A] ^ sr[TAP_B]);
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Error-rate window for the locked checker: counts bits and errors per window
// and raises unlock when too many errors land in one window.
module prbs_err_window #(
    parameter int WINDOW      = 32,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic err,
    input  logic locked,
    output logic unlock
);

    localparam int WB_W = $clog2(WINDOW + 1);
    localparam int WE_W = $clog2(UNLOCK_ERRS + 1);
    localparam logic [WB_W-1:0] WB_LAST = WB_W'(WINDOW - 1);
    localparam logic [WE_W-1:0] WE_LAST = WE_W'(UNLOCK_ERRS - 1);

    logic [WB_W-1:0] r_win_bits;
    logic [WE_W-1:0] r_win_errs;
    logic            w_count;
    logic            w_win_end;

    assign w_count   = valid & locked;
    assign w_win_end = (r_win_bits == WB_LAST);
    // Unlock is checked independently of the window boundary so it wins on the last bit.
    assign unlock    = w_count & err & (r_win_errs == WE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_bits <= '0;
            r_win_errs <= '0;
        end else if (!locked) begin
            r_win_bits <= '0;
            r_win_errs <= '0;
        end else if (w_count) begin
            if (unlock || w_win_end) begin
                r_win_bits <= '0;
                r_win_errs <= '0;
            end else begin
                r_win_bits <= r_win_bits + 1'b1;
                r_win_errs <= r_win_errs + WE_W'(err);
            end
        end
    end

endmodule

// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS5 receive checker: seeds from the line, hunts for a run
// of correct predictions, then counts bit errors against a free-running reference.
module prbs5_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT  = 8,
    parameter int WINDOW      = 32,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic                 din,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lock_lost,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [MC_W-1:0] MATCH_TGT = MC_W'(LOCK_COUNT);
    localparam logic [2:0]      SEED_LAST = 3'(LFSR_W - 1);

    prbs_state_e          r_state, w_state_nxt;
    logic [LFSR_W-1:0]    r_sr, w_sr_nxt;
    logic [2:0]           r_seed_cnt, w_seed_nxt;
    logic [MC_W-1:0]      r_match_cnt, w_match_nxt;
    logic [ERR_CNT_W-1:0] r_err_count, w_err_nxt;
    logic                 r_locked, r_err_pulse, r_lock_lost;
    logic                 w_pred, w_in_locked, w_bit_err, w_unlock;

    assign w_pred      = prbs5_next(r_sr);
    assign w_in_locked = (r_state == LOCKED);
    assign w_bit_err   = din_valid & w_in_locked & (din != w_pred);

    prbs_err_window #(
        .WINDOW      (WINDOW),
        .UNLOCK_ERRS (UNLOCK_ERRS)
    ) u_err_window (
        .clk    (clk),
        .rst    (rst),
        .valid  (din_valid),
        .err    (w_bit_err),
        .locked (w_in_locked),
        .unlock (w_unlock)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_seed_nxt  = r_seed_cnt;
        w_match_nxt = r_match_cnt;
        if (din_valid) begin
            unique case (r_state)
                SEED: begin
                    w_sr_nxt = {r_sr[LFSR_W-2:0], din};
                    if (r_seed_cnt == SEED_LAST) begin
                        w_state_nxt = HUNT;
                        w_seed_nxt  = '0;
                        w_match_nxt = '0;
                    end else begin
                        w_seed_nxt = r_seed_cnt + 3'd1;
                    end
                end
                HUNT: begin
                    w_sr_nxt = {r_sr[LFSR_W-2:0], din};
                    if ((din == w_pred) && (w_sr_nxt != LOCKUP))
                        w_match_nxt = r_match_cnt + 1'b1;
                    else
                        w_match_nxt = '0;
                    if (w_match_nxt == MATCH_TGT) begin
                        w_state_nxt = LOCKED;
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so one corrupted bit is counted once.
                    w_sr_nxt = {r_sr[LFSR_W-2:0], w_pred};
                    if (w_unlock)
                        w_state_nxt = SEED;
                end
                default: w_state_nxt = SEED;
            endcase
        end

        w_err_nxt = r_err_count;
        if (w_bit_err && !(&r_err_count))
            w_err_nxt = r_err_count + 1'b1;
        if (clear_cnt)
            w_err_nxt = ERR_CNT_W'(w_bit_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SEED;
            r_sr        <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_err_count <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_seed_cnt  <= w_seed_nxt;
            r_match_cnt <= w_match_nxt;
            r_err_count <= w_err_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_bit_err;
            r_lock_lost <= w_unlock;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign lock_lost = r_lock_lost;
    assign err_count = r_err_count;

endmodule
